// File: rtl/stream_fifo_ctrl.sv
// Valid/ready streaming FIFO controller for an external simple dual-port RAM.
// Owns the write/read pointers, drives both RAM ports and presents the RAM
// read data on a registered output stream. Works with combinational-read
// (READ_LATENCY=0) and registered-read (READ_LATENCY=1) RAM builds.
//
// Handshake: a word moves on a port in any cycle where valid and ready are
// both high at the rising clock edge; the sender holds valid and data stable
// until that happens, and ready never depends combinationally on valid.
module stream_fifo_ctrl #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 10,
    parameter int READ_LATENCY = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [DEPTH-1:0]   ram_waddress,
    output logic [WIDTH-1:0]   ram_din,
    output logic               ram_we,
    output logic [DEPTH-1:0]   ram_raddress,
    output logic               ram_oe,
    input  logic [WIDTH-1:0]   ram_dout,
    output logic [DEPTH+1:0]   count,
    input  logic [31:0]        ram_length
);

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $fatal(1, "stream_fifo_ctrl: READ_LATENCY must be 0 or 1");
    end

    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]   ram_count_q, ram_count_d;
    logic [DEPTH+1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             inflight_q, inflight_d;

    logic             accept;
    logic             pop;
    logic             issue;
    logic             slot_free;
    logic [1:0]       occupancy;

    // The RAM length is informational; fold it into a deliberately unused net.
    logic unused_ram_length;
    assign unused_ram_length = ^ram_length;

    // Handshake decode and read-issue decision, all from registered state.
    always_comb begin
        in_ready  = !reset && !ram_count_q[DEPTH];
        accept    = in_valid && in_ready;
        pop       = out_valid_q && out_ready;
        occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
        if (READ_LATENCY == 0) begin
            slot_free = !out_valid_q || pop;
        end else begin
            // Output + skid + in-flight, net of this cycle's pop, must leave
            // room for the word that returns next cycle.
            slot_free = (occupancy - {1'b0, pop}) < 2'd2;
        end
        issue = !reset && (ram_count_q != '0) && slot_free;
    end

    // Next-state for pointers, occupancy counters and output/skid stages.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_count_d  = ram_count_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        inflight_d   = 1'b0;

        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (issue)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({accept, issue})
            2'b10:   ram_count_d = ram_count_q + 1'b1;
            2'b01:   ram_count_d = ram_count_q - 1'b1;
            default: ram_count_d = ram_count_q;
        endcase

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (READ_LATENCY == 0) begin
            // Combinational read: data is captured at the same edge it is issued.
            if (issue) begin
                out_valid_d = 1'b1;
                out_data_d  = ram_dout;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Registered read: data returns one cycle after issue.
            inflight_d = issue;
            if (pop && skid_valid_q) begin
                // Skid is older than any returning word, so it drains first.
                out_data_d   = skid_data_q;
                skid_valid_d = inflight_q;
                if (inflight_q) skid_data_d = ram_dout;
            end else if (pop || !out_valid_q) begin
                out_valid_d = inflight_q;
                if (inflight_q) out_data_d = ram_dout;
            end else if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = ram_dout;
            end
        end
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            inflight_q   <= inflight_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign ram_waddress = wr_ptr_q;
    assign ram_din      = in_data;
    assign ram_we       = accept;
    assign ram_raddress = rd_ptr_q;
    assign ram_oe       = issue;
    assign count        = count_q;

endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// Bench for stream_fifo_ctrl: one instance per RAM read latency (DEPTH=2),
// each with its own behavioural RAM. Lanes are exercised one after another.
module tb_stream_fifo_ctrl;

    localparam int W = 32;
    localparam int D = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]         in_valid, in_ready, out_valid, out_ready, ram_we, ram_oe;
    logic [1:0][W-1:0]  in_data, out_data, ram_din;
    logic [1:0][D-1:0]  ram_waddress, ram_raddress;
    logic [1:0][D+1:0]  count;
    logic [W-1:0]       dout0, dout1;
    logic [W-1:0]       mem0 [4];
    logic [W-1:0]       mem1 [4];

    stream_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .ram_waddress(ram_waddress[0]), .ram_din(ram_din[0]), .ram_we(ram_we[0]),
        .ram_raddress(ram_raddress[0]), .ram_oe(ram_oe[0]), .ram_dout(dout0),
        .count(count[0]), .ram_length(32'd4)
    );

    stream_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .ram_waddress(ram_waddress[1]), .ram_din(ram_din[1]), .ram_we(ram_we[1]),
        .ram_raddress(ram_raddress[1]), .ram_oe(ram_oe[1]), .ram_dout(dout1),
        .count(count[1]), .ram_length(32'd4)
    );

    // Behavioural RAMs: combinational read for lane 0, registered read for lane 1.
    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_waddress[0]] <= ram_din[0];
        if (ram_we[1]) mem1[ram_waddress[1]] <= ram_din[1];
        if (ram_oe[1]) dout1 <= mem1[ram_raddress[1]];
    end
    assign dout0 = mem0[ram_raddress[0]];

    // ---------------- bench state ----------------
    int lane = 0;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int src_pct = 0;
    int snk_pct = 0;
    int model_count = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int acc_mark = -1;
    int vld_mark = -1;
    int vld_cycles = 0;
    int stall_cnt = 0;
    bit acc_pend = 0;
    bit prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic [W-1:0] last_out = '0;
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];

    task automatic chk(input string nm, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s lane=%0d cyc=%0d: got %0h expected %0h", nm, lane, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- driver tasks / processes ----------------
    // Acceptance: the word on the bus is taken at the coming edge -> expect it.
    always @(negedge clk) begin
        if (!reset && in_valid[lane] && in_ready[lane]) begin
            exp_q.push_back(in_data[lane]);
            src_q.delete(0);
            acc_pend = 1'b1;
        end
    end

    // Source holds a word until taken; sink toggles out_ready at snk_pct.
    always @(posedge clk) begin
        #1;
        if (!in_valid[lane] || acc_pend) begin
            in_valid[lane] = 1'b0;
            if (src_q.size() > 0 && $urandom_range(99) < src_pct) begin
                in_valid[lane] = 1'b1;
                in_data[lane]  = src_q[0];
            end
        end
        acc_pend = 1'b0;
        out_ready[lane] = ($urandom_range(99) < snk_pct);
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((src_q.size() != 0 || model_count != 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, (src_q.size() == 0 && model_count == 0), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        bit acc, pop;
        logic [W-1:0] exp;
        if (reset) begin
            chk("reset_in_ready", in_ready[lane], 0);
            chk("reset_we", ram_we[lane], 0);
            exp_q.delete();
            model_count = 0;
            wr_cnt = 0;
            rd_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            acc = in_valid[lane] && in_ready[lane];
            pop = out_valid[lane] && out_ready[lane];
            chk("count", count[lane], model_count);
            chk("count_le_max", count[lane] <= 5 + lane, 1);
            if (model_count < 4) chk("in_ready_room", in_ready[lane], 1);
            if (model_count == 5 + lane) chk("in_ready_full", in_ready[lane], 0);
            if (model_count == 0) begin
                chk("empty_out_valid", out_valid[lane], 0);
                chk("empty_ram_oe", ram_oe[lane], 0);
            end
            chk("we_is_accept", ram_we[lane], acc);
            if (ram_we[lane]) begin
                chk("waddr", ram_waddress[lane], wr_cnt % 4);
                chk("din", ram_din[lane], in_data[lane]);
                wr_cnt++;
            end
            if (ram_oe[lane]) begin
                chk("raddr", ram_raddress[lane], rd_cnt % 4);
                rd_cnt++;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid[lane], 1);
                chk("stall_data", out_data[lane], prev_data);
            end
            if (pop) begin
                chk("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    chk("data", out_data[lane], exp);
                end
                last_out = out_data[lane];
            end
            if (out_valid[lane]) vld_cycles++;
            if (out_valid[lane] && vld_mark < 0) vld_mark = cyc;
            if (acc && acc_mark < 0) acc_mark = cyc;
            if (out_valid[lane] && !out_ready[lane]) stall_cnt++;
            prev_stall = out_valid[lane] && !out_ready[lane];
            prev_data  = out_data[lane];
            model_count += int'(acc) - int'(pop);
        end
    end

    // ---------------- directed + random sequence per lane ----------------
    task automatic run_lane();
        int n;
        do_reset(2);

        // Back-to-back fall-through with a free sink.
        snk_pct = 100; src_pct = 100;
        acc_mark = -1; vld_mark = -1; vld_cycles = 0;
        src_q.push_back(32'h11); src_q.push_back(32'h22); src_q.push_back(32'h33);
        wait_drain("t1_drain", 60);
        chk("t1_latency", vld_mark - acc_mark, 2 + lane);
        chk("t1_valid_cycles", vld_cycles, 3);

        // Fill to full with the sink stalled, then release.
        snk_pct = 0;
        for (int i = 0; i < 6; i++) src_q.push_back(32'hA0 + i);
        repeat (20) @(negedge clk);
        #1;
        chk("full_accepted", 6 - src_q.size(), 5 + lane);
        chk("full_count", count[lane], 5 + lane);
        chk("full_in_ready", in_ready[lane], 0);
        snk_pct = 100;
        wait_drain("full_drain", 80);

        // Pointer wrap over a continuous 20-word stream.
        do_reset(1);
        for (int i = 0; i < 20; i++) src_q.push_back($urandom);
        wait_drain("wrap_drain", 120);
        chk("wrap_writes", wr_cnt, 20);
        chk("wrap_reads", rd_cnt, 20);

        // Sink stalls for 5 cycles mid-stream.
        stall_cnt = 0;
        for (int i = 0; i < 12; i++) src_q.push_back($urandom);
        repeat (4) @(posedge clk);
        snk_pct = 0;
        repeat (5) @(posedge clk);
        snk_pct = 100;
        wait_drain("stall_drain", 120);
        chk("stall_seen", stall_cnt >= 4, 1);

        // Random traffic at 50% on both sides.
        src_pct = 50; snk_pct = 50;
        for (int i = 0; i < 2000; i++) src_q.push_back($urandom);
        wait_drain("random_drain", 30000);

        // Reset while holding 3 words; a fresh word must come out first.
        src_pct = 100; snk_pct = 0;
        for (int i = 0; i < 3; i++) src_q.push_back(32'hC0 + i);
        n = 0;
        while (model_count != 3 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("pre_reset_held", model_count, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_out_valid", out_valid[lane], 0);
        chk("post_reset_count", count[lane], 0);
        chk("post_reset_in_ready", in_ready[lane], 1);
        snk_pct = 100;
        src_q.push_back(32'hAB);
        wait_drain("post_reset_drain", 40);
        chk("post_reset_first", last_out, 32'hAB);
    endtask

    initial begin
        in_valid = '0; out_ready = '0; in_data = '0;
        for (int l = 0; l < 2; l++) begin
            lane = l;
            src_pct = 0; snk_pct = 0;
            run_lane();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
